// File: rtl/multicycle_control_unit.sv
// Multicycle RV32-style control FSM: fetch/decode/execute/memory/writeback with trap handling.
// Optional feature macro CUSTOM_OP_EN: when defined, CUSTOM0 executes as an R-type op and raises custom_sel.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] opcode,
  input  logic       mem_ready,
  input  logic       trap_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_is_instr,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       branch,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] wb_sel,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic       custom_sel,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [4:0] OPC_LOAD    = 5'b00000;
  localparam logic [4:0] OPC_STORE   = 5'b01000;
  localparam logic [4:0] OPC_BRANCH  = 5'b11000;
  localparam logic [4:0] OPC_JALR    = 5'b11001;
  localparam logic [4:0] OPC_JAL     = 5'b11011;
  localparam logic [4:0] OPC_OP_IMM  = 5'b00100;
  localparam logic [4:0] OPC_OP      = 5'b01100;
  localparam logic [4:0] OPC_AUIPC   = 5'b00101;
  localparam logic [4:0] OPC_LUI     = 5'b01101;
  localparam logic [4:0] OPC_SYSTEM  = 5'b11100;
  localparam logic [4:0] OPC_CUSTOM0 = 5'b00010;

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  logic [2:0]    state_q;
  logic [2:0]    next_state;
  logic [4:0]    op_q;
  logic [1:0]    cause_q;
  logic [1:0]    next_cause;
  logic [CW-1:0] wait_cnt;
  logic          timeout_hit;
  logic          op_custom;
  logic [1:0]    exec_a;
  logic [1:0]    exec_b;
  logic [1:0]    exec_op;

  function automatic logic is_legal(input logic [4:0] opc);
    logic ok;
    case (opc)
      OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR, OPC_JAL,
      OPC_OP_IMM, OPC_OP, OPC_AUIPC, OPC_LUI, OPC_SYSTEM: ok = 1'b1;
`ifdef CUSTOM_OP_EN
      OPC_CUSTOM0: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

`ifdef CUSTOM_OP_EN
  assign op_custom = (op_q == OPC_CUSTOM0);
`else
  assign op_custom = 1'b0;
`endif

  // The final permitted wait cycle expires unless mem_ready arrives in that same cycle
  assign timeout_hit = (MEM_TIMEOUT > 0) && !mem_ready && (wait_cnt == LAST_WAIT);
  assign state       = state_q;
  assign trap_cause  = cause_q;

  // State and trap-cause registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cause_q <= 2'd0;
    end else begin
      state_q <= next_state;
      cause_q <= next_cause;
    end
  end

  // Opcode latch, captured while the IR contents are being decoded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= 5'd0;
    end else if (state_q == S_DECODE) begin
      op_q <= opcode;
    end else begin
      op_q <= op_q;
    end
  end

  // Memory wait counter: zeroed on every state change, saturating while waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= {CW{1'b0}};
    end else if (next_state != state_q) begin
      wait_cnt <= {CW{1'b0}};
    end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready && !(&wait_cnt)) begin
      wait_cnt <= wait_cnt + CW'(1);
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

  // Next-state and trap-cause selection
  always_comb begin
    next_state = S_IDLE;
    next_cause = cause_q;
    case (state_q)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          next_state = S_DECODE;
        end else if (timeout_hit) begin
          next_state = S_TRAP;
          next_cause = 2'd2;
        end else begin
          next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        if (!is_legal(opcode)) begin
          next_state = S_TRAP;
          next_cause = 2'd1;
        end else if (opcode == OPC_SYSTEM) begin
          next_state = S_TRAP;
          next_cause = 2'd3;
        end else begin
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_q)
          OPC_LOAD, OPC_STORE: next_state = S_MEM;
          OPC_BRANCH:          next_state = S_FETCH;
          default:             next_state = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          next_state = (op_q == OPC_STORE) ? S_FETCH : S_WB;
        end else if (timeout_hit) begin
          next_state = S_TRAP;
          next_cause = 2'd2;
        end else begin
          next_state = S_MEM;
        end
      end
      S_WB: next_state = S_FETCH;
      S_TRAP: begin
        if (trap_ack) begin
          next_state = S_FETCH;
          next_cause = 2'd0;
        end else begin
          next_state = S_TRAP;
        end
      end
      default: begin
        next_state = S_IDLE;
        next_cause = 2'd0;
      end
    endcase
  end

  // ALU operand/operation selection from the latched opcode, held from EXEC through WB
  always_comb begin
    exec_a  = 2'b00;
    exec_b  = 2'b00;
    exec_op = 2'b00;
    case (op_q)
      OPC_LOAD, OPC_STORE, OPC_JALR: exec_b = 2'b01;
      OPC_OP:                        exec_op = 2'b10;
`ifdef CUSTOM_OP_EN
      OPC_CUSTOM0:                   exec_op = 2'b10;
`endif
      OPC_OP_IMM: begin
        exec_b  = 2'b01;
        exec_op = 2'b11;
      end
      OPC_AUIPC, OPC_JAL: begin
        exec_a = 2'b01;
        exec_b = 2'b01;
      end
      OPC_LUI: begin
        exec_a = 2'b10;
        exec_b = 2'b01;
      end
      OPC_BRANCH: exec_op = 2'b01;
      default: begin
        exec_a  = 2'b00;
        exec_b  = 2'b00;
        exec_op = 2'b00;
      end
    endcase
  end

  // Output decode per state
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_instr = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    branch       = 1'b0;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    wb_sel       = 2'b00;
    trap         = 1'b0;
    custom_sel   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req      = 1'b1;
        mem_is_instr = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
        end else begin
          ir_write  = 1'b0;
          pc_write  = 1'b0;
        end
      end
      S_EXEC: begin
        alu_src_a  = exec_a;
        alu_src_b  = exec_b;
        alu_op     = exec_op;
        branch     = (op_q == OPC_BRANCH);
        custom_sel = op_custom;
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = (op_q == OPC_STORE);
        alu_src_a = exec_a;
        alu_src_b = exec_b;
        alu_op    = exec_op;
      end
      S_WB: begin
        reg_write  = 1'b1;
        alu_src_a  = exec_a;
        alu_src_b  = exec_b;
        alu_op     = exec_op;
        custom_sel = op_custom;
        if (op_q == OPC_LOAD) begin
          wb_sel = 2'b01;
        end else if (op_q == OPC_JAL || op_q == OPC_JALR) begin
          wb_sel   = 2'b10;
          pc_write = 1'b1;
        end else begin
          wb_sel = 2'b00;
        end
      end
      S_TRAP: trap = 1'b1;
      default: trap = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: an instruction-level model expands each scenario into per-cycle stimulus
// and expected outputs; one compare process checks every cycle against it.
module tb_multicycle_control_unit;

  localparam int TMO = 4;
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;
  localparam int NX_MEM = 0, NX_WB = 1, NX_FETCH = 2;

  typedef struct packed {
    logic       rst_n;
    logic       mem_ready;
    logic       trap_ack;
    logic [4:0] opcode;
  } stim_t;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req, mem_we, mem_is_instr, ir_write, pc_write, reg_write, branch;
    logic [1:0] a, b, op, wb;
    logic       trap;
    logic [1:0] cause;
    logic       custom;
  } exp_t;

  typedef struct {
    bit         legal, system, custom, jump, store;
    logic [1:0] a, b, op, wb;
    int         next;
  } dec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] opcode = 5'd0;
  logic       mem_ready = 1'b0;
  logic       trap_ack = 1'b0;
  logic       mem_req, mem_we, mem_is_instr, ir_write, pc_write, reg_write, branch;
  logic [1:0] alu_src_a, alu_src_b, alu_op, wb_sel;
  logic       trap, custom_sel;
  logic [1:0] trap_cause;
  logic [2:0] state;

  multicycle_control_unit #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .trap_ack(trap_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_is_instr(mem_is_instr), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .branch(branch), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .wb_sel(wb_sel), .trap(trap),
    .trap_cause(trap_cause), .custom_sel(custom_sel), .state(state)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  stim_t sq[$];
  exp_t  eq[$];
  exp_t  cur_exp;
  exp_t  dut_vec;
  bit    chk_en = 1'b0;
  int    cur_idx = 0;

  assign dut_vec = {state, mem_req, mem_we, mem_is_instr, ir_write, pc_write, reg_write, branch,
                    alu_src_a, alu_src_b, alu_op, wb_sel, trap, trap_cause, custom_sel};

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (dut_vec !== cur_exp) begin
        errors++;
        $display("FAIL cycle %0d outputs: got %h (state %0d) expected %h (state %0d)",
                 cur_idx, dut_vec, dut_vec.state, cur_exp, cur_exp.state);
      end
    end
  end

  function automatic exp_t blank(input logic [2:0] st);
    exp_t e;
    e = '0;
    e.state = st;
    return e;
  endfunction

  // Instruction table: what each opcode must do
  function automatic dec_t spec_decode(input logic [4:0] opc);
    dec_t d;
    d.legal = 1; d.system = 0; d.custom = 0; d.jump = 0; d.store = 0;
    d.a = 2'd0; d.b = 2'd0; d.op = 2'd0; d.wb = 2'd0; d.next = NX_WB;
    case (opc)
      5'b00000: begin d.b = 2'd1; d.next = NX_MEM; d.wb = 2'd1; end
      5'b01000: begin d.b = 2'd1; d.next = NX_MEM; d.store = 1; end
      5'b11000: begin d.op = 2'd1; d.next = NX_FETCH; end
      5'b11001: begin d.b = 2'd1; d.wb = 2'd2; d.jump = 1; end
      5'b11011: begin d.a = 2'd1; d.b = 2'd1; d.wb = 2'd2; d.jump = 1; end
      5'b00100: begin d.b = 2'd1; d.op = 2'd3; end
      5'b01100: d.op = 2'd2;
      5'b00101: begin d.a = 2'd1; d.b = 2'd1; end
      5'b01101: begin d.a = 2'd2; d.b = 2'd1; end
      5'b11100: d.system = 1;
`ifdef CUSTOM_OP_EN
      5'b00010: begin d.op = 2'd2; d.custom = 1; end
`endif
      default: d.legal = 0;
    endcase
    return d;
  endfunction

  task automatic push(input logic rn, input logic mr, input logic ta, input logic [4:0] opc,
                      input exp_t e);
    stim_t s;
    s.rst_n = rn; s.mem_ready = mr; s.trap_ack = ta; s.opcode = opc;
    sq.push_back(s);
    eq.push_back(e);
  endtask

  task automatic do_trap(input logic [4:0] opc, input logic [1:0] cause, input int ack_delay,
                         input bit noise);
    exp_t e;
    e = blank(S_TRAP);
    e.trap = 1'b1;
    e.cause = cause;
    for (int i = 0; i < ack_delay; i++) push(1'b1, noise, 1'b0, opc, e);
    push(1'b1, noise, 1'b1, opc, e);
  endtask

  // delay cycles with mem_ready low, then a ready cycle; only TMO low cycles are tolerated
  task automatic do_wait(input logic [4:0] opc, input int delay, input exp_t wait_e,
                         input exp_t done_e, output bit to);
    int n;
    n = delay;
    to = 1'b0;
    if (TMO > 0 && delay >= TMO) begin
      n = TMO;
      to = 1'b1;
    end
    for (int i = 0; i < n; i++) push(1'b1, 1'b0, 1'b0, opc, wait_e);
    if (!to) push(1'b1, 1'b1, 1'b0, opc, done_e);
  endtask

  task automatic add_instr(input logic [4:0] opc, input int fd, input int md, input int ack,
                           input bit noise);
    dec_t d;
    exp_t w, r, e;
    bit   to;
    d = spec_decode(opc);
    w = blank(S_FETCH);
    w.mem_req = 1'b1;
    w.mem_is_instr = 1'b1;
    r = w;
    r.ir_write = 1'b1; r.pc_write = 1'b1; r.a = 2'd1; r.b = 2'd2;
    do_wait(opc, fd, w, r, to);
    if (to) begin do_trap(opc, 2'd2, ack, noise); return; end
    push(1'b1, noise, 1'b0, opc, blank(S_DECODE));
    if (!d.legal) begin do_trap(opc, 2'd1, ack, noise); return; end
    if (d.system) begin do_trap(opc, 2'd3, ack, noise); return; end
    e = blank(S_EXEC);
    e.a = d.a; e.b = d.b; e.op = d.op;
    e.branch = (d.next == NX_FETCH);
    e.custom = d.custom;
    push(1'b1, noise, 1'b0, opc, e);
    if (d.next == NX_FETCH) return;
    if (d.next == NX_MEM) begin
      w = blank(S_MEM);
      w.mem_req = 1'b1; w.mem_we = d.store; w.a = d.a; w.b = d.b; w.op = d.op;
      do_wait(opc, md, w, w, to);
      if (to) begin do_trap(opc, 2'd2, ack, noise); return; end
      if (d.store) return;
    end
    e = blank(S_WB);
    e.reg_write = 1'b1; e.wb = d.wb; e.pc_write = d.jump;
    e.a = d.a; e.b = d.b; e.op = d.op; e.custom = d.custom;
    push(1'b1, noise, 1'b0, opc, e);
  endtask

  task automatic pin(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  initial begin
    int   idle_op, ld_s, ld_e, to_s, to_e, n;
    int   seq[6];
    exp_t w;
    seq = '{0, 1, 2, 3, 5, 1};

    push(1'b0, 1'b0, 1'b0, 5'b01100, blank(S_IDLE));
    push(1'b0, 1'b1, 1'b0, 5'b01100, blank(S_IDLE));
    idle_op = sq.size();
    push(1'b1, 1'b0, 1'b0, 5'b01100, blank(S_IDLE));
    add_instr(5'b01100, 0, 0, 0, 1'b0);
    ld_s = sq.size();
    add_instr(5'b00000, 1, 3, 0, 1'b1);
    ld_e = sq.size();
    add_instr(5'b01000, 0, 0, 0, 1'b0);
    add_instr(5'b00100, 2, 0, 0, 1'b1);
    add_instr(5'b00101, 0, 0, 0, 1'b0);
    add_instr(5'b01101, 0, 0, 0, 1'b0);
    add_instr(5'b11011, 0, 0, 0, 1'b1);
    add_instr(5'b11001, 1, 0, 0, 1'b0);
    add_instr(5'b11000, 0, 0, 0, 1'b1);
    to_s = sq.size();
    add_instr(5'b01100, 9, 0, 2, 1'b0);
    to_e = sq.size();
    add_instr(5'b01101, 3, 0, 0, 1'b0);
    add_instr(5'b00000, 0, 4, 0, 1'b0);
    add_instr(5'b01000, 0, 3, 0, 1'b0);
    add_instr(5'b11111, 0, 0, 1, 1'b1);
    add_instr(5'b11100, 0, 0, 0, 1'b0);
    add_instr(5'b00010, 0, 0, 0, 1'b0);
    add_instr(5'b00001, 0, 0, 0, 1'b0);
    // STORE interrupted by reset while waiting in MEM
    add_instr(5'b01000, 0, 9, 0, 1'b0);
    void'(sq.pop_back()); void'(eq.pop_back());
    void'(sq.pop_back()); void'(eq.pop_back());
    void'(sq.pop_back()); void'(eq.pop_back());
    push(1'b0, 1'b1, 1'b0, 5'b01000, blank(S_IDLE));
    push(1'b1, 1'b0, 1'b0, 5'b01000, blank(S_IDLE));
    add_instr(5'b01100, 0, 0, 0, 1'b0);
    w = blank(S_FETCH);
    w.mem_req = 1'b1; w.mem_is_instr = 1'b1;
    push(1'b1, 1'b0, 1'b0, 5'b01100, w);

    for (int k = 0; k < 6; k++) pin("op_state_seq", int'(eq[idle_op + k].state), seq[k]);
    n = 0;
    for (int k = idle_op; k < ld_s; k++) n += int'(eq[k].reg_write);
    pin("op_reg_write_cycles", n, 1);
    n = 0;
    for (int k = ld_s; k < ld_e; k++) n += (eq[k].state == S_MEM) ? 1 : 0;
    pin("load_mem_cycles", n, 4);
    pin("load_wb_sel", int'(eq[ld_e - 1].wb), 1);
    n = 0;
    for (int k = to_s; k < to_e; k++) n += (eq[k].state == S_FETCH) ? 1 : 0;
    pin("timeout_fetch_cycles", n, 4);
    pin("timeout_cause", int'(eq[to_e - 1].cause), 2);
    pin("store_reset_mem_we", int'(eq[sq.size() - 8].mem_we), 1);

    for (int i = 0; i < sq.size(); i++) begin
      @(posedge clk);
      #1;
      rst_n     = sq[i].rst_n;
      mem_ready = sq[i].mem_ready;
      trap_ack  = sq[i].trap_ack;
      opcode    = sq[i].opcode;
      cur_exp   = eq[i];
      cur_idx   = i;
      chk_en    = 1'b1;
    end
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
